// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port write-first BRAM between a write
// requester and a read requester, with a 2-entry credit-gated read response FIFO.
module sp_ram_arbiter #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_data_valid,
  input  logic                  rd_data_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_di,
  input  logic [WIDTH-1:0]      ram_dout
);

  // Handshake: a transfer happens in any cycle where valid & ready are both high;
  // ready depends combinationally on valid, read credit and the priority pointer.

  localparam logic PRIO_WR = 1'b0;
  localparam logic PRIO_RD = 1'b1;

  if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_cfg
    $error("sp_ram_arbiter: ADDR_WIDTH too small for DEPTH");
  end

  logic             prio_q, prio_d;
  logic             rd_pend_q, rd_pend_d;
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];

  logic       push, pop;
  logic [2:0] credit;
  logic       rd_ok, rd_elig, wr_elig;
  logic       grant_wr, grant_rd;

  always_comb begin
    pop     = (count_q != 2'd0) & rd_data_ready;
    push    = rd_pend_q;
    // Outstanding responses after this cycle's pop; a new read needs a free slot.
    credit  = {1'b0, count_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    rd_ok   = credit < 3'd2;
    rd_elig = rd_req_valid & rd_ok & ~rst;
    wr_elig = wr_valid & ~rst;

    grant_wr = wr_elig & (~rd_elig | (prio_q == PRIO_WR));
    grant_rd = rd_elig & (~wr_elig | (prio_q == PRIO_RD));

    prio_d = prio_q;
    if (grant_wr)      prio_d = PRIO_RD;
    else if (grant_rd) prio_d = PRIO_WR;

    rd_pend_d = grant_rd;

    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = ram_dout;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    wr_ready      = grant_wr;
    rd_req_ready  = grant_rd;
    ram_en        = grant_wr | grant_rd;
    ram_we        = grant_wr;
    ram_addr      = grant_rd ? rd_addr : wr_addr;
    ram_di        = wr_data;
    rd_data_valid = (count_q != 2'd0);
    rd_data       = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q    <= PRIO_WR;
      rd_pend_q <= 1'b0;
      count_q   <= 2'd0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
    end else begin
      assert (!(push && !pop && (count_q == 2'd2)))
        else $error("sp_ram_arbiter: response FIFO overflow");
      prio_q    <= prio_d;
      rd_pend_q <= rd_pend_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      mem_q[0]  <= mem_d[0];
      mem_q[1]  <= mem_d[1];
    end
  end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural write-first BRAM model.
module tb_sp_ram_arbiter;

  localparam int WIDTH = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_valid, wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_req_valid, rd_req_ready;
  logic [AW-1:0]    rd_addr;
  logic             rd_data_valid, rd_data_ready;
  logic [WIDTH-1:0] rd_data;
  logic             ram_en, ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_di, ram_dout;

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  int passed = 0;
  int total  = 0;

  sp_ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_dout(ram_dout)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_di;
        ram_dout      <= ram_di;
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    int acc;
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req_valid = 1'b0; rd_addr = '0; rd_data_ready = 1'b0;

    // reset: requests must be ignored while rst is high
    cyc(); wr_valid = 1'b1; rd_req_valid = 1'b1; #1;
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_rd_req_ready", 32'(rd_req_ready), 0);
    check("rst_ram_en", 32'(ram_en), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_rd_data_valid", 32'(rd_data_valid), 0);

    // write A5A5 to 5, read it back
    cyc(); rst = 1'b0; rd_req_valid = 1'b0; rd_data_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 10'd5; wr_data = 16'hA5A5; #1;
    check("t1_wr_ready", 32'(wr_ready), 1);
    check("t1_wr_we", 32'(ram_we), 1);
    check("t1_wr_addr", 32'(ram_addr), 5);
    check("t1_wr_di", 32'(ram_di), 32'hA5A5);
    cyc(); wr_valid = 1'b0; rd_req_valid = 1'b1; rd_addr = 10'd5; #1;
    check("t1_rd_ready", 32'(rd_req_ready), 1);
    check("t1_rd_en", 32'(ram_en), 1);
    check("t1_rd_we", 32'(ram_we), 0);
    cyc(); rd_req_valid = 1'b0; #1;
    check("t1_valid_n1", 32'(rd_data_valid), 0);
    check("t1_idle_en", 32'(ram_en), 0);
    cyc(); #1;
    check("t1_valid_n2", 32'(rd_data_valid), 1);
    check("t1_data", 32'(rd_data), 32'hA5A5);
    cyc(); #1;
    check("t1_drained", 32'(rd_data_valid), 0);

    // both streaming: W,R,W,R...
    for (int i = 0; i < 8; i++) begin
      cyc();
      wr_valid = 1'b1; rd_req_valid = 1'b1; rd_addr = 10'd5;
      wr_addr = 10'(100 + i / 2); wr_data = 16'(32'h1000 + i / 2); #1;
      check("t2_ram_en", 32'(ram_en), 1);
      check("t2_wr_ready", 32'(wr_ready), (i % 2 == 0) ? 1 : 0);
      check("t2_rd_ready", 32'(rd_req_ready), (i % 2 == 1) ? 1 : 0);
      if (i >= 3) check("t2_resp_valid", 32'(rd_data_valid), (i % 2 == 1) ? 1 : 0);
      if (i >= 3 && i % 2 == 1) check("t2_resp_data", 32'(rd_data), 32'hA5A5);
    end
    cyc(); wr_valid = 1'b0; rd_req_valid = 1'b0; #1;
    check("t2_tail_gap", 32'(rd_data_valid), 0);
    cyc(); #1;
    check("t2_tail_valid", 32'(rd_data_valid), 1);
    check("t2_tail_data", 32'(rd_data), 32'hA5A5);
    cyc(); #1;
    for (int j = 0; j < 4; j++) check("t2_mem", 32'(mem[100 + j]), 32'h1000 + j);

    // preload 0..5 = 10..15 and 7 = DEAD through the arbiter
    for (int j = 0; j < 7; j++) begin
      cyc(); wr_valid = 1'b1;
      wr_addr = (j == 6) ? 10'd7 : 10'(j);
      wr_data = (j == 6) ? 16'hDEAD : 16'(10 + j); #1;
      check("t3_pre_wr_ready", 32'(wr_ready), 1);
    end
    // 6 back-to-back reads
    for (int i = 0; i < 8; i++) begin
      cyc(); wr_valid = 1'b0;
      rd_req_valid = (i < 6); rd_addr = 10'(i); #1;
      if (i < 6) check("t3_rd_ready", 32'(rd_req_ready), 1);
      if (i >= 2) begin
        check("t3_valid", 32'(rd_data_valid), 1);
        check("t3_data", 32'(rd_data), 32'(10 + i - 2));
      end
    end
    cyc(); rd_req_valid = 1'b0; #1;
    check("t3_drained", 32'(rd_data_valid), 0);

    // backpressure: only 2 reads accepted, write still flows
    rd_data_ready = 1'b0; acc = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(); rd_req_valid = 1'b1; rd_addr = 10'(acc);
      wr_valid = (i == 3); wr_addr = 10'd200; wr_data = 16'hBEEF; #1;
      check("t4_rd_ready", 32'(rd_req_ready), (i < 2) ? 1 : 0);
      if (i < 2) acc++;
      if (i == 3) begin
        check("t4_wr_ready", 32'(wr_ready), 1);
        check("t4_full_valid", 32'(rd_data_valid), 1);
        check("t4_full_head", 32'(rd_data), 10);
      end
    end
    cyc(); wr_valid = 1'b0; rd_data_ready = 1'b1; rd_addr = 10'(acc); #1;
    check("t4_resume_ready", 32'(rd_req_ready), 1);
    check("t4_drain0", 32'(rd_data), 10);
    cyc(); rd_addr = 10'd3; #1;
    check("t4_resume_ready2", 32'(rd_req_ready), 1);
    check("t4_drain1", 32'(rd_data), 11);
    cyc(); rd_req_valid = 1'b0; #1;
    check("t4_drain2_valid", 32'(rd_data_valid), 1);
    check("t4_drain2", 32'(rd_data), 12);
    cyc(); #1;
    check("t4_drain3", 32'(rd_data), 13);
    cyc(); #1;
    check("t4_empty", 32'(rd_data_valid), 0);
    check("t4_mem200", 32'(mem[200]), 32'hBEEF);

    // read-after-write on addr 7
    cyc(); wr_valid = 1'b1; wr_addr = 10'd7; wr_data = 16'h1234; #1;
    check("t5_wr_ready", 32'(wr_ready), 1);
    cyc(); wr_valid = 1'b0; rd_req_valid = 1'b1; rd_addr = 10'd7; #1;
    check("t5_rd_ready", 32'(rd_req_ready), 1);
    cyc(); rd_req_valid = 1'b0;
    cyc(); #1;
    check("t5_valid", 32'(rd_data_valid), 1);
    check("t5_data", 32'(rd_data), 32'h1234);
    cyc();

    // reset with a read in flight
    cyc(); rd_req_valid = 1'b1; rd_addr = 10'd0; #1;
    check("t6_rd_ready", 32'(rd_req_ready), 1);
    cyc(); rd_req_valid = 1'b0; rst = 1'b1; wr_valid = 1'b1; wr_addr = 10'd300; wr_data = 16'h5555; #1;
    check("t6_rst_en", 32'(ram_en), 0);
    check("t6_rst_wr_ready", 32'(wr_ready), 0);
    cyc(); rst = 1'b0; wr_valid = 1'b0; #1;
    check("t6_no_resp_a", 32'(rd_data_valid), 0);
    cyc(); #1;
    check("t6_no_resp_b", 32'(rd_data_valid), 0);
    // pointer must return to WRITE after reset
    cyc(); wr_valid = 1'b1; wr_addr = 10'd301; wr_data = 16'h0001; #1;
    check("t6_pre_wr", 32'(wr_ready), 1);
    cyc(); wr_valid = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0; wr_valid = 1'b1; wr_addr = 10'd302; rd_req_valid = 1'b1; rd_addr = 10'd5; #1;
    check("t6_post_wr_ready", 32'(wr_ready), 1);
    check("t6_post_rd_ready", 32'(rd_req_ready), 0);
    cyc(); wr_addr = 10'd303; #1;
    check("t6_post2_rd_ready", 32'(rd_req_ready), 1);
    check("t6_post2_wr_ready", 32'(wr_ready), 0);
    cyc(); wr_valid = 1'b0; rd_req_valid = 1'b0;
    cyc(); cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
Round-robin controller that shares one single-port write-first BRAM (WIDTH x DEPTH, 1-cycle read latency) between a write requester and a read requester. Issues at most one RAM access per cycle and drives the RAM's en/we/addr/di directly. Returns read data through a 2-entry response FIFO with valid/ready backpressure. Read issue is gated by credit so no response is ever dropped. Sits between weight/output staging logic and on-chip buffer RAMs.

Parameters:
WIDTH, 16, data width of RAM word
DEPTH, 1024, RAM depth in words
ADDR_WIDTH, 10, RAM address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
wr_valid  in  1  write request valid
wr_ready  out  1  write request accepted this cycle
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  WIDTH  write data
rd_req_valid  in  1  read request valid
rd_req_ready  out  1  read request accepted this cycle
rd_addr  in  ADDR_WIDTH  read address
rd_data_valid  out  1  read response valid
rd_data_ready  in  1  read response consumer ready
rd_data  out  WIDTH  read response data
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_WIDTH  RAM address
ram_di  out  WIDTH  RAM write data
ram_dout  in  WIDTH  RAM read data, valid the cycle after a read issue

Behaviour:
- Single clock, clk; reset rst is synchronous, active-high.
- Reset values: wr_ready=0, rd_req_ready=0, ram_en=0, ram_we=0, rd_data_valid=0. rd_data is don't-care. Response FIFO is empty, pending flag is cleared, priority pointer is set to WRITE.
- Handshakes: a transfer occurs when valid&ready. Ready is combinational from the valids, the credit and the priority pointer. Requesters must hold valid, addr and data stable until accepted.
- Read credit: rd_ok = (fifo_count + rd_pend - pop) < 2, where pop = rd_data_valid & rd_data_ready.
- Arbitration, evaluated each cycle:
  - Only wr_valid: grant the write.
  - Only rd_req_valid with rd_ok: grant the read.
  - Both eligible: grant the side indicated by the priority pointer; the pointer then flips to the other side.
  - A single-requester grant also sets the pointer to the other side.
  - A read blocked by credit does not block the write.
- Grant outputs (combinational, same cycle):
  - Write grant: ram_en=1, ram_we=1, ram_addr=wr_addr, ram_di=wr_data, wr_ready=1.
  - Read grant: ram_en=1, ram_we=0, ram_addr=rd_addr, rd_req_ready=1.
  - No grant: ram_en=0, ram_we=0.
- Read pipeline:
  - Read accepted in cycle N sets rd_pend for cycle N+1.
  - In N+1, ram_dout is pushed into the FIFO.
  - rd_data_valid=1 in N+2 at the earliest. Read latency is 2 cycles.
  - Responses are returned in request order.
- FIFO: 2 entries, registered head output.
  - Push and pop in the same cycle is legal; count is unchanged.
  - Credit guarantees a push never targets a full FIFO. Overflow is an assertion failure.
- Ordering: write accepted in cycle N, then read of the same address accepted in cycle N+k (k>=1) returns the new data.
- Throughput: with rd_data_ready held high, back-to-back reads are sustained at 1 per cycle.
- Alternating grants give each side 50% when both stream continuously.
- ram_dout is sampled only when rd_pend=1; dout changes caused by write-first writes are ignored.
- Addresses >= DEPTH are not checked; keeping them in range is the requester's responsibility.
- rst asserted mid-operation:
  - The in-flight read (rd_pend) is discarded and the FIFO contents are dropped.
  - No RAM access is issued during the reset cycle.
  - Requester state is not preserved.

Test Plan:
- Reset, then write 0xA5A5 to addr 5, then read addr 5 -> ram_we=1 in cycle 1 only; rd_data_valid=1 with rd_data=0xA5A5 exactly 2 cycles after rd_req accepted.
- wr_valid and rd_req_valid both held high for 8 cycles, rd_data_ready=1 -> grants alternate W,R,W,R... starting with W after reset; 4 writes and 4 reads, ram_en=1 every cycle.
- 6 back-to-back reads (addr 0..5, preloaded 10..15), rd_data_ready=1 -> rd_req_ready=1 every cycle; responses 10..15 on consecutive cycles.
- Reads streaming with rd_data_ready=0 -> exactly 2 reads accepted, then rd_req_ready=0; FIFO holds 2; a concurrent write is still granted. Raise ready -> responses drain in order, reads resume.
- Write addr 7=0x1234, next cycle read addr 7 -> returns 0x1234, never stale data.
- Read accepted, rst pulsed in the next cycle -> rd_data_valid stays 0; FIFO is empty after reset; the first post-reset grant with both requesters valid goes to the write.
